// File: rtl/spi_slave_core.sv
// SPI responder: oversamples sclk/ss_n/mosi in the clk_i domain, handles all
// four CPOL/CPHA modes, and shifts DATA_W-bit frames through a one-deep
// ready/valid TX holding register and a pulsed RX output.
module spi_slave_core #(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              sclk_i,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              tx_underrun_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state;
  logic [2:0]         sclk_s;
  logic [2:0]         ss_s;
  logic [1:0]         mosi_s;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  tx_sh;
  logic [DATA_W-1:0]  rx_sh;
  logic [DATA_W-1:0]  rx_next;
  logic [DATA_W-1:0]  hold_data;
  logic [DATA_W-1:0]  load_data;
  logic               sclk_rise;
  logic               sclk_fall;
  logic               lead_edge;
  logic               trail_edge;
  logic               sample_edge;
  logic               shift_edge;
  logic               ss_fall;
  logic               ss_rise;
  logic               last_bit;
  logic               load;
  logic               write;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  // Two-flop synchronizers plus a third flop on sclk/ss_n for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_s <= {3{cpol}};
      ss_s   <= '1;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], sclk_i};
      ss_s   <= {ss_s[1:0], ss_n_i};
      mosi_s <= {mosi_s[0], mosi_i};
    end
  end

  // Edge classification, RX shift value and holding-register load decode
  always_comb begin
    sclk_rise   = sclk_s[1] & ~sclk_s[2];
    sclk_fall   = ~sclk_s[1] & sclk_s[2];
    lead_edge   = cpol ? sclk_fall : sclk_rise;
    trail_edge  = cpol ? sclk_rise : sclk_fall;
    sample_edge = cpha ? trail_edge : lead_edge;
    shift_edge  = cpha ? lead_edge : trail_edge;
    ss_fall     = ~ss_s[1] & ss_s[2];
    ss_rise     = ss_s[1] & ~ss_s[2];
    last_bit    = (cnt == CNT_W'(DATA_W - 1));
    if (LSB_FIRST != 0) rx_next = {mosi_s[1], rx_sh[DATA_W-1:1]};
    else                rx_next = {rx_sh[DATA_W-2:0], mosi_s[1]};
    // An empty holding register (ready high) supplies an all-zero frame
    load_data = tx_ready_o ? '0 : hold_data;
    load      = ((state == IDLE) && ss_fall) ||
                ((state == ACTIVE) && !ss_rise && sample_edge && last_bit);
    write     = tx_valid_i & tx_ready_o;
  end

  // Frame FSM, shift registers and TX holding register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      hold_data     <= '0;
      tx_ready_o    <= 1'b1;
      miso_o        <= 1'b0;
      miso_oe_o     <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      frame_err_o   <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      frame_err_o   <= 1'b0;

      // A write can only land while empty, so a simultaneous load sees the
      // old (empty) contents and the new word stays queued.
      if (write) begin
        hold_data  <= tx_data_i;
        tx_ready_o <= 1'b0;
      end else if (load) begin
        tx_ready_o <= 1'b1;
      end
      if (load) tx_underrun_o <= tx_ready_o;

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state     <= ACTIVE;
            miso_oe_o <= 1'b1;
            cnt       <= '0;
            if (!cpha) begin
              miso_o <= first_bit(load_data);
              tx_sh  <= shift_out(load_data);
            end else begin
              tx_sh  <= load_data;
            end
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state     <= IDLE;
            miso_oe_o <= 1'b0;
            miso_o    <= 1'b0;
            cnt       <= '0;
            if (cnt != '0) frame_err_o <= 1'b1;
          end else if (sample_edge) begin
            rx_sh <= rx_next;
            if (last_bit) begin
              cnt        <= '0;
              rx_data_o  <= rx_next;
              rx_valid_o <= 1'b1;
              if (!cpha) begin
                miso_o <= first_bit(load_data);
                tx_sh  <= shift_out(load_data);
              end else begin
                tx_sh  <= load_data;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (shift_edge && (cpha || (cnt != '0))) begin
            // cpha=0: a zero count here means the trailing edge after the
            // last sample, where the reloaded first bit must stay on miso.
            miso_o <= first_bit(tx_sh);
            tx_sh  <= shift_out(tx_sh);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_core.sv
// Scoreboard bench for spi_slave_core: an MSB-first and an LSB-first instance
// share one bus-functional SPI master; a behavioural model predicts frames.
module tb_spi_slave_core;

  localparam int W = 8;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpol = 1'b0, cpha = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;

  logic miso_m, oe_m, ready_m, rxv_m, und_m, ferr_m;
  logic miso_l, oe_l, ready_l, rxv_l, und_l, ferr_l;
  logic [W-1:0] rx_data_m, rx_data_l;

  int checks = 0, errors = 0;
  logic [W-1:0] rx_exp_m[$], rx_exp_l[$], tx_model[$];
  logic [W-1:0] cur_tx = '0, last_rx = '0, e_m, e_l;
  int exp_rxv = 0, exp_und = 0, exp_ferr = 0;
  int rxv_cnt = 0, und_cnt = 0, ferr_cnt = 0, und_cnt_l = 0, ferr_cnt_l = 0;

  always #5 clk = ~clk;

  spi_slave_core #(.DATA_W(W), .LSB_FIRST(0)) dut (
    .clk_i(clk), .rst_i(rst), .cpol(cpol), .cpha(cpha), .sclk_i(sclk),
    .ss_n_i(ss_n), .mosi_i(mosi), .miso_o(miso_m), .miso_oe_o(oe_m),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(ready_m),
    .rx_data_o(rx_data_m), .rx_valid_o(rxv_m), .tx_underrun_o(und_m),
    .frame_err_o(ferr_m));

  spi_slave_core #(.DATA_W(W), .LSB_FIRST(1)) dut_l (
    .clk_i(clk), .rst_i(rst), .cpol(cpol), .cpha(cpha), .sclk_i(sclk),
    .ss_n_i(ss_n), .mosi_i(mosi), .miso_o(miso_l), .miso_oe_o(oe_l),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(ready_l),
    .rx_data_o(rx_data_l), .rx_valid_o(rxv_l), .tx_underrun_o(und_l),
    .frame_err_o(ferr_l));

  function automatic logic [W-1:0] rev8(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected RX words on every rx_valid pulse, counts pulses
  always @(negedge clk) begin
    if (rxv_m) begin
      rxv_cnt++;
      if (rx_exp_m.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected_m: got %0h expected no frame", rx_data_m);
      end else begin
        e_m = rx_exp_m.pop_front();
        check("rx_data_m", rx_data_m, e_m);
      end
    end
    if (rxv_l) begin
      if (rx_exp_l.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected_l: got %0h expected no frame", rx_data_l);
      end else begin
        e_l = rx_exp_l.pop_front();
        check("rx_data_l", rx_data_l, e_l);
      end
    end
    if (und_m) und_cnt++;
    if (ferr_m) ferr_cnt++;
    if (und_l) und_cnt_l++;
    if (ferr_l) ferr_cnt_l++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every frame start consumes one queued word or an underrun zero frame
  task automatic model_load();
    if (tx_model.size() != 0) cur_tx = tx_model.pop_front();
    else begin
      cur_tx = '0;
      exp_und++;
    end
  endtask

  task automatic hold_write(input logic [W-1:0] v);
    int t = 0;
    while (ready_m !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (ready_m !== 1'b1) begin
      checks++; errors++;
      $display("FAIL hold_write_timeout: tx_ready_o=%b required 1", ready_m);
      return;
    end
    tx_data = v;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_model.push_back(v);
    check("tx_ready_drop_m", ready_m, 0);
    check("tx_ready_drop_l", ready_l, 0);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    sclk = p;
    cpha = h;
    cyc(6);
  endtask

  task automatic ss_assert();
    ss_n = 1'b0;
    model_load();
  endtask

  task automatic ss_release(input bit partial);
    cyc(H);
    ss_n = 1'b1;
    if (partial) exp_ferr++;
    cyc(6);
    check("oe_idle_m", oe_m, 0);
    check("oe_idle_l", oe_l, 0);
    check("rx_valid_count", rxv_cnt, exp_rxv);
    check("underrun_count_m", und_cnt, exp_und);
    check("underrun_count_l", und_cnt_l, exp_und);
    check("frame_err_count_m", ferr_cnt, exp_ferr);
    check("frame_err_count_l", ferr_cnt_l, exp_ferr);
  endtask

  // Master clocks nbits bits of mo (MSB first on the wire) and captures miso
  task automatic spi_frame(input logic [W-1:0] mo, input int nbits);
    logic [W-1:0] got_m, got_l, exp_tx;
    bit stable;
    logic pm, pl;
    exp_tx = cur_tx;
    got_m = '0;
    got_l = '0;
    stable = 1'b1;
    if (nbits == W) begin
      rx_exp_m.push_back(mo);
      rx_exp_l.push_back(rev8(mo));
      exp_rxv++;
      last_rx = mo;
    end
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = mo[W-1-i];
        cyc(H - 2);
      end else begin
        cyc(H);
        sclk = ~sclk;
        mosi = mo[W-1-i];
        cyc(H - 2);
      end
      pm = miso_m;
      pl = miso_l;
      cyc(2);
      sclk = ~sclk;
      got_m[W-1-i] = miso_m;
      got_l[W-1-i] = miso_l;
      if (miso_m !== pm || miso_l !== pl) stable = 1'b0;
      cyc(1);
      if (miso_m !== got_m[W-1-i] || miso_l !== got_l[W-1-i]) stable = 1'b0;
      if (i == 0) check("oe_during_frame", oe_m, 1);
      cyc(H - 1);
      if (!cpha) sclk = ~sclk;
    end
    if (nbits == W) begin
      check("miso_word_m", got_m, exp_tx);
      check("miso_word_l", got_l, rev8(exp_tx));
      check("miso_stable", stable, 1);
      model_load();
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_miso"}, miso_m, 0);
    check({tag, "_oe"}, oe_m, 0);
    check({tag, "_ready"}, ready_m, 1);
    check({tag, "_rx_data"}, rx_data_m, 0);
    check({tag, "_rx_valid"}, rxv_m, 0);
    check({tag, "_underrun"}, und_m, 0);
    check({tag, "_frame_err"}, ferr_m, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] v;
    int nfr;
    cyc(3);
    check_reset("reset");
    rst = 1'b0;
    cyc(1);
    check_reset("post_reset");
    cyc(2);

    // Mode 0 basic transfer
    hold_write(8'hA5);
    ss_assert();
    cyc(5);
    check("tx_ready_after_start", ready_m, tx_model.size() == 0);
    check("oe_active_l", oe_l, 1);
    spi_frame(8'h3C, W);
    ss_release(0);

    // Modes 1..3
    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      hold_write(8'h81);
      ss_assert();
      spi_frame(8'h7E, W);
      ss_release(0);
    end

    // Back-to-back frames, second word queued during the first frame
    set_mode(1'b0, 1'b0);
    hold_write(8'h11);
    ss_assert();
    fork
      begin
        spi_frame(8'hC6, W);
        spi_frame(8'h39, W);
      end
      begin
        cyc(3 * H);
        hold_write(8'h22);
      end
    join
    ss_release(0);

    // Underrun: nothing queued
    ss_assert();
    spi_frame(8'($urandom), W);
    ss_release(0);

    // Partial frame: error pulse, rx_data keeps the last frame
    hold_write(8'($urandom));
    ss_assert();
    spi_frame(8'($urandom), 5);
    ss_release(1);
    check("rx_data_kept", rx_data_m, last_rx);
    hold_write(8'($urandom));
    ss_assert();
    spi_frame(8'($urandom), W);
    ss_release(0);

    // Synchronous reset mid-frame
    hold_write(8'h99);
    ss_assert();
    spi_frame(8'hC3, 3);
    rst = 1'b1;
    ss_n = 1'b1;
    sclk = cpol;
    mosi = 1'b0;
    cyc(1);
    check_reset("mid_reset");
    rst = 1'b0;
    tx_model.delete();
    last_rx = '0;
    cyc(1);
    check_reset("mid_post_reset");
    cyc(4);
    hold_write(8'hA5);
    ss_assert();
    spi_frame(8'h5A, W);
    ss_release(0);

    // Randomized modes, words and frame counts
    for (int it = 0; it < 16; it++) begin
      v = 8'($urandom);
      set_mode(v[0], v[1]);
      nfr = int'($urandom_range(1, 2));
      if (($urandom % 5) != 0) hold_write(8'($urandom));
      ss_assert();
      for (int f = 0; f < nfr; f++) spi_frame(8'($urandom), W);
      if (($urandom % 6) == 0) begin
        spi_frame(8'($urandom), int'($urandom_range(1, W - 1)));
        ss_release(1);
      end else begin
        ss_release(0);
      end
    end

    check("rx_queue_drained_m", rx_exp_m.size(), 0);
    check("rx_queue_drained_l", rx_exp_l.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
